// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480 timing constants, receiver states and pixel packing
package vga_pkg;
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} rx_state_t;

    function automatic logic [7:0] rgb444_to_332(input logic [3:0] r, input logic [3:0] g,
                                                 input logic [3:0] b);
        return {r[3:1], g[3:1], b[3:2]};
    endfunction
endpackage

// File: rtl/vga_sync_tracker.sv
// rtl/vga_sync_tracker.sv - sync edge detection, position counters and timing checks
module vga_sync_tracker #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] hc_now,
    output logic [9:0] vc_now,
    output logic       vfall,
    output logic       herr,
    output logic       verr
);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_START = 10'(V_VIS + V_FP);

    logic       hs_q;
    logic       vs_q;
    logic       hfall;
    logic [9:0] hc_r;
    logic [9:0] vc_r;

    assign hfall = hs_q & ~hsync;
    assign vfall = vs_q & ~vsync;

    // Sync falls snap the counters to the position where that edge belongs.
    always_comb begin
        hc_now = (hc_r == H_LAST) ? 10'd0 : hc_r + 10'd1;
        if (hfall)
            hc_now = H_START;
        vc_now = vc_r;
        if (vfall)
            vc_now = V_START;
        else if (hc_now == 10'd0)
            vc_now = (vc_r == V_LAST) ? 10'd0 : vc_r + 10'd1;
    end

    assign herr = hfall ^ (hc_r == H_START - 10'd1);
    assign verr = vfall ^ ((hc_now == 10'd0) && (vc_r == V_START - 10'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            hc_r <= '0;
            vc_r <= '0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            hc_r <= hc_now;
            vc_r <= vc_now;
        end
    end
endmodule

// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - VGA receive decoder: lock FSM, pixel output and frame-buffer address
module vga_rx_decoder #(
    parameter int H_VIS       = vga_pkg::H_VIS,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_VIS       = vga_pkg::V_VIS,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int LOCK_FRAMES = 2,
    parameter int SCALE       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic [7:0]  px_data,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
);
    localparam logic [15:0] FB_W     = 16'(H_VIS >> SCALE);
    localparam logic [9:0]  LOW_MASK = 10'((1 << SCALE) - 1);

    vga_pkg::rx_state_t state;
    logic [3:0]  good_cnt;
    logic [9:0]  hc_now;
    logic [9:0]  vc_now;
    logic        vfall;
    logic        herr;
    logic        verr;
    logic        err;
    logic        vis;
    logic        aligned;
    logic [15:0] row;
    logic [15:0] col;

    vga_sync_tracker #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_tracker (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .hc_now(hc_now), .vc_now(vc_now), .vfall(vfall), .herr(herr), .verr(verr)
    );

    assign err     = (state != vga_pkg::SEARCH) && (herr || verr);
    assign vis     = (state == vga_pkg::LOCKED) && !err &&
                     (hc_now < 10'(H_VIS)) && (vc_now < 10'(V_VIS));
    assign aligned = ((hc_now & LOW_MASK) == 10'd0) && ((vc_now & LOW_MASK) == 10'd0);
    assign row     = 16'(vc_now >> SCALE);
    assign col     = 16'(hc_now >> SCALE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= vga_pkg::SEARCH;
            good_cnt    <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_data     <= '0;
            fb_addr     <= '0;
            fb_we       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                vga_pkg::SEARCH: begin
                    if (vfall) begin
                        state    <= vga_pkg::ALIGN;
                        good_cnt <= '0;
                    end
                end
                vga_pkg::ALIGN: begin
                    if (err) begin
                        sync_err <= 1'b1;
                        state    <= vga_pkg::SEARCH;
                    end else if (vfall) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
                            state  <= vga_pkg::LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                vga_pkg::LOCKED: begin
                    if (err) begin
                        sync_err <= 1'b1;
                        locked   <= 1'b0;
                        state    <= vga_pkg::SEARCH;
                    end
                end
                default: state <= vga_pkg::SEARCH;
            endcase

            px_valid    <= vis;
            fb_we       <= vis && aligned;
            frame_start <= vis && (hc_now == 10'd0) && (vc_now == 10'd0);
            // Position/data/address hold their last visible value between pixels.
            if (vis) begin
                px_x    <= hc_now;
                px_y    <= vc_now;
                px_data <= vga_pkg::rgb444_to_332(red, green, blue);
                fb_addr <= row * FB_W + col;
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - randomized-pixel bench for vga_rx_decoder on a reduced raster
module tb_vga_rx_decoder;
    localparam int HV = 32, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
    localparam int VV = 16, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam int LF = 2, SC = 2, FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic [9:0]  px_x, px_y;
    logic        px_valid, fb_we, frame_start, locked, sync_err;
    logic [7:0]  px_data;
    logic [15:0] fb_addr;

    vga_rx_decoder #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_FRAMES(LF), .SCALE(SC)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .px_data(px_data),
        .fb_addr(fb_addr), .fb_we(fb_we), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int h = 0, v = 0;
    int inj_h_line = -1;
    bit drop_v = 1'b0;
    bit prev_vs = 1'b1;
    bit trk = 1'b0, lk = 1'b0;
    int good = 0;
    int ex_x = 0, ex_y = 0, ex_d = 0, ex_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_px_valid"}, 32'(px_valid), 0);
        check({pfx, "_px_x"}, 32'(px_x), 0);
        check({pfx, "_px_y"}, 32'(px_y), 0);
        check({pfx, "_px_data"}, 32'(px_data), 0);
        check({pfx, "_fb_addr"}, 32'(fb_addr), 0);
        check({pfx, "_fb_we"}, 32'(fb_we), 0);
        check({pfx, "_frame_start"}, 32'(frame_start), 0);
        check({pfx, "_locked"}, 32'(locked), 0);
        check({pfx, "_sync_err"}, 32'(sync_err), 0);
    endtask

    task automatic model_reset();
        trk = 1'b0; lk = 1'b0; good = 0;
        ex_x = 0; ex_y = 0; ex_d = 0; ex_a = 0;
        prev_vs = 1'b1;
    endtask

    // One pixel clock of a generator-style raster at (h,v), with optional injected faults.
    task automatic cycle();
        logic        hs, vs;
        logic [11:0] c;
        bit          vfall_ev, fault_ev, err, valid, lk_next;
        c = 12'($urandom);
        if (h == 0 && v == 0) c = 12'hF0A;
        hs = !(h >= HV + HF && h < HV + HF + HS) && !(h == HV + HF - 1 && v == inj_h_line);
        vs = !(v >= VV + VF && v < VV + VF + VS) || drop_v;
        hsync = hs; vsync = vs;
        red = c[11:8]; green = c[7:4]; blue = c[3:0];
        if (rst) begin
            @(posedge clk); #1;
            check_zero("in_rst");
            prev_vs = 1'b1;
        end else begin
            vfall_ev = prev_vs && !vs;
            fault_ev = (!hs && h == HV + HF - 1) || (drop_v && v == VV + VF && h == 0);
            prev_vs  = vs;
            err = 1'b0;
            lk_next = lk;
            if (!trk) begin
                if (vfall_ev) begin trk = 1'b1; good = 0; end
            end else if (fault_ev) begin
                err = 1'b1; trk = 1'b0; lk_next = 1'b0;
            end else if (vfall_ev && !lk) begin
                good++;
                if (good == LF) lk_next = 1'b1;
            end
            valid = lk && !err && h < HV && v < VV;
            if (valid) begin
                ex_x = h; ex_y = v;
                ex_d = {c[11:9], c[7:5], c[3:2]};
                ex_a = (v / (1 << SC)) * (HV / (1 << SC)) + h / (1 << SC);
            end
            @(posedge clk); #1;
            check("px_valid", 32'(px_valid), 32'(valid));
            check("px_x", 32'(px_x), ex_x);
            check("px_y", 32'(px_y), ex_y);
            check("px_data", 32'(px_data), ex_d);
            check("fb_addr", 32'(fb_addr), ex_a);
            check("fb_we", 32'(fb_we), 32'(valid && h % (1 << SC) == 0 && v % (1 << SC) == 0));
            check("frame_start", 32'(frame_start), 32'(valid && h == 0 && v == 0));
            check("locked", 32'(locked), 32'(lk_next));
            check("sync_err", 32'(sync_err), 32'(err));
            if (valid && h == 0 && v == 0) begin
                check("origin_px_data", 32'(px_data), 32'h0E2);
                check("origin_fb_addr", 32'(fb_addr), 0);
            end
            if (valid && h == HV - 4 && v == VV - 4)
                check("last_aligned_fb_addr", 32'(fb_addr), 31);
            if (valid && h == HV - 1 && v == VV - 1)
                check("last_px_fb_we", 32'(fb_we), 0);
            lk = lk_next;
        end
        if (h == HV + HF - 1 && v == inj_h_line) inj_h_line = -1;
        if (drop_v && v == VV + VF + VS - 1 && h == HT - 1) drop_v = 1'b0;
        h++;
        if (h == HT) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        run(4 * FRAME);
        check("lock_initial", 32'(locked), 1);
        run(FRAME);

        inj_h_line = 5;
        run(4 * FRAME);
        check("relock_after_hsync", 32'(locked), 1);

        drop_v = 1'b1;
        run(4 * FRAME);
        check("relock_after_vsync", 32'(locked), 1);

        run(3 * HT + 10);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        run(FRAME - (3 * HT + 12));
        run(3 * FRAME);
        check("relock_after_rst", 32'(locked), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
